mvm_loader: RTL

Front-end sequencer that fills the MVM block's vector and per-lane matrix memories from a single valid/ready word stream, then launches the multiplication and reports completion. It sits between the host/DMA stream and the MVM write, start and parameter ports. It drives every MVM input except clk/rst, and observes only the MVM busy output.

---
 rtl/mvm_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mvm_loader.sv
// mvm_loader: fills the MVM vector and per-lane matrix memories from one word stream,
// then launches the multiply and reports completion.
`timescale 1ns/1ps
module mvm_loader #(
    parameter int IWIDTH        = 8,
    parameter int MEM_DATAW     = IWIDTH * 8,
    parameter int VEC_MEM_DEPTH = 256,
    parameter int VEC_ADDRW     = $clog2(VEC_MEM_DEPTH),
    parameter int MAT_MEM_DEPTH = 512,
    parameter int MAT_ADDRW     = $clog2(MAT_MEM_DEPTH),
    parameter int NUM_OLANES    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [VEC_ADDRW-1:0]  i_vec_base,
    input  logic [VEC_ADDRW:0]    i_vec_num_words,
    input  logic [MAT_ADDRW-1:0]  i_mat_base,
    input  logic [MAT_ADDRW:0]    i_mat_num_rows,
    input  logic [MEM_DATAW-1:0]  s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  i_mvm_busy,
    output logic [MEM_DATAW-1:0]  o_vec_wdata,
    output logic [VEC_ADDRW-1:0]  o_vec_waddr,
    output logic                  o_vec_wen,
    output logic [MEM_DATAW-1:0]  o_mat_wdata,
    output logic [MAT_ADDRW-1:0]  o_mat_waddr,
    output logic [NUM_OLANES-1:0] o_mat_wen,
    output logic                  o_start,
    output logic [VEC_ADDRW-1:0]  o_vec_start_addr,
    output logic [VEC_ADDRW:0]    o_vec_num_words,
    output logic [MAT_ADDRW-1:0]  o_mat_start_addr,
    output logic [MAT_ADDRW:0]    o_mat_num_rows_per_olane,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    localparam int LW = $clog2(NUM_OLANES);
    localparam int PW = MAT_ADDRW + VEC_ADDRW + 2;
    localparam logic [VEC_ADDRW:0] W_ONE  = 1;
    localparam logic [MAT_ADDRW:0] R_ONE  = 1;
    localparam logic [LW-1:0]      L_ONE  = 1;
    localparam logic [LW-1:0]      L_LAST = LW'(NUM_OLANES - 1);

    typedef enum logic [2:0] {IDLE, LD_VEC, LD_MAT, WAIT_FREE, START, RUN} state_t;

    state_t                 state_q, state_d;
    logic [VEC_ADDRW-1:0]   vbase_q, vbase_d;
    logic [VEC_ADDRW:0]     k_q, k_d, w_q, w_d;
    logic [MAT_ADDRW-1:0]   mbase_q, mbase_d;
    logic [MAT_ADDRW:0]     r_q, r_d, row_q, row_d, rb_q, rb_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic                   first_q, first_d, done_q, done_d, err_q, err_d;
    logic                   vwen_q, vwen_d;
    logic [VEC_ADDRW-1:0]   vwaddr_q, vwaddr_d;
    logic [MEM_DATAW-1:0]   vwdata_q, vwdata_d, mwdata_q, mwdata_d;
    logic [NUM_OLANES-1:0]  mwen_q, mwen_d;
    logic [MAT_ADDRW-1:0]   mwaddr_q, mwaddr_d;

    // Descriptor bounds checked at full width so R*K and the end addresses never wrap.
    logic [PW-1:0]          rk;
    logic [VEC_ADDRW+1:0]   vec_end;
    logic [PW:0]            mat_end;
    logic                   cfg_ok;
    assign rk      = PW'(i_mat_num_rows) * PW'(i_vec_num_words);
    assign vec_end = (VEC_ADDRW+2)'(i_vec_base) + (VEC_ADDRW+2)'(i_vec_num_words);
    assign mat_end = (PW+1)'(i_mat_base) + (PW+1)'(rk);
    assign cfg_ok  = (i_vec_num_words != '0) && (i_mat_num_rows != '0) &&
                     (vec_end <= (VEC_ADDRW+2)'(VEC_MEM_DEPTH)) &&
                     (mat_end <= (PW+1)'(MAT_MEM_DEPTH));

    logic [VEC_ADDRW:0] wn, vec_sum;
    logic [MAT_ADDRW:0] mat_sum;
    logic               last_w;
    assign wn      = w_q + W_ONE;
    assign last_w  = wn == k_q;
    assign vec_sum = (VEC_ADDRW+1)'(vbase_q) + w_q;
    assign mat_sum = (MAT_ADDRW+1)'(mbase_q) + rb_q + (MAT_ADDRW+1)'(w_q);

    always_comb begin
        state_d  = state_q;
        vbase_d  = vbase_q;
        k_d      = k_q;
        mbase_d  = mbase_q;
        r_d      = r_q;
        w_d      = w_q;
        lane_d   = lane_q;
        row_d    = row_q;
        rb_d     = rb_q;
        first_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        vwen_d   = 1'b0;
        vwaddr_d = vwaddr_q;
        vwdata_d = vwdata_q;
        mwen_d   = '0;
        mwaddr_d = mwaddr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: if (i_cfg_valid) begin
                err_d = !cfg_ok;
                if (cfg_ok) begin
                    state_d = LD_VEC;
                    vbase_d = i_vec_base;
                    k_d     = i_vec_num_words;
                    mbase_d = i_mat_base;
                    r_d     = i_mat_num_rows;
                    w_d     = '0;
                    lane_d  = '0;
                    row_d   = '0;
                    rb_d    = '0;
                end
            end
            LD_VEC: if (s_valid) begin
                vwen_d   = 1'b1;
                vwaddr_d = vec_sum[VEC_ADDRW-1:0];
                vwdata_d = s_data;
                w_d      = last_w ? '0 : wn;
                state_d  = last_w ? LD_MAT : LD_VEC;
            end
            LD_MAT: if (s_valid) begin
                mwen_d   = NUM_OLANES'(1) << lane_q;
                mwaddr_d = mat_sum[MAT_ADDRW-1:0];
                mwdata_d = s_data;
                w_d      = last_w ? '0 : wn;
                if (last_w) begin
                    lane_d = (lane_q == L_LAST) ? '0 : lane_q + L_ONE;
                    if (lane_q == L_LAST) begin
                        rb_d    = rb_q + (MAT_ADDRW+1)'(k_q);
                        row_d   = row_q + R_ONE;
                        state_d = (row_q + R_ONE == r_q) ? WAIT_FREE : LD_MAT;
                    end
                end
            end
            WAIT_FREE: state_d = i_mvm_busy ? WAIT_FREE : START;
            START: begin
                state_d = RUN;
                first_d = 1'b1;
            end
            // The MVM raises busy only after seeing start, so the first RUN cycle is skipped.
            RUN: if (!first_q && !i_mvm_busy) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            vbase_q  <= '0;
            k_q      <= '0;
            mbase_q  <= '0;
            r_q      <= '0;
            w_q      <= '0;
            lane_q   <= '0;
            row_q    <= '0;
            rb_q     <= '0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            vwen_q   <= 1'b0;
            vwaddr_q <= '0;
            vwdata_q <= '0;
            mwen_q   <= '0;
            mwaddr_q <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            vbase_q  <= vbase_d;
            k_q      <= k_d;
            mbase_q  <= mbase_d;
            r_q      <= r_d;
            w_q      <= w_d;
            lane_q   <= lane_d;
            row_q    <= row_d;
            rb_q     <= rb_d;
            first_q  <= first_d;
            done_q   <= done_d;
            err_q    <= err_d;
            vwen_q   <= vwen_d;
            vwaddr_q <= vwaddr_d;
            vwdata_q <= vwdata_d;
            mwen_q   <= mwen_d;
            mwaddr_q <= mwaddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign o_cfg_ready              = state_q == IDLE;
    assign s_ready                  = (state_q == LD_VEC) || (state_q == LD_MAT);
    assign o_start                  = state_q == START;
    assign o_busy                   = state_q != IDLE;
    assign o_done                   = done_q;
    assign o_err                    = err_q;
    assign o_vec_wen                = vwen_q;
    assign o_vec_waddr              = vwaddr_q;
    assign o_vec_wdata              = vwdata_q;
    assign o_mat_wen                = mwen_q;
    assign o_mat_waddr              = mwaddr_q;
    assign o_mat_wdata              = mwdata_q;
    assign o_vec_start_addr         = vbase_q;
    assign o_vec_num_words          = k_q;
    assign o_mat_start_addr         = mbase_q;
    assign o_mat_num_rows_per_olane = r_q;
endmodule
